macc_18x18: RTL and testbench
=============================

// Module: macc_18x18
// PURPOSE
//  Signed 18x18 multiply-accumulate slice modelling the FPGA hard MAC: optional A/B input
//  registers, a product adder, and an optional P output register.
//  Used by complex and wide multipliers; slices chain through cdout -> cdin.
// PARAMETERS
//  BYPASS_REG_A  0   1 = A input register bypassed (combinational)
//  BYPASS_REG_B  0   1 = B input register bypassed
//  BYPASS_REG_P  0   1 = P output register bypassed
//  P_WIDTH       44  adder/result width (41 for legacy family, 48 for newest)
// PORTS
//  clk      in   1        single clock, rising edge
//  grst     in   1        asynchronous active-high reset, all registers
//  srst_n   in   1        synchronous active-low clear of A, B, P registers
//  en_a     in   1        A register load enable
//  en_b     in   1        B register load enable
//  en_p     in   1        P register load enable
//  a        in   18       signed multiplicand
//  b        in   18       signed multiplicand
//  c        in   P_WIDTH  signed addend (unregistered)
//  carryin  in   1        LSB carry into adder
//  cdin     in   P_WIDTH  cascade input from adjacent slice's cdout
//  cdsel    in   1        1 = addend Y from cdin, 0 = Y from feedback mux
//  fdbksel  in   1        Y when cdsel=0: 1 = P feedback (only with macro), else 0
//  shftsel  in   1        1 = Y arithmetically shifted right by 17 before add
//  sub      in   1        1 = subtract product
//  p        out  P_WIDTH  result
//  cdout    out  P_WIDTH  cascade out; always equal to p
//  ovfl     out  1        signed overflow of the final add
// BEHAVIOUR
//  - Reset: grst asserted -> A, B, P, ovfl registers = 0 immediately (even mid-op).
//    srst_n=0 at a clock edge -> same, and takes priority over enables.
//  - Reset value: all outputs 0.
//  - Ar/Br = registered a/b (bypass: live inputs); a register holds when its enable is 0.
//  - M = Ar*Br: 36-bit signed product, sign-extended to P_WIDTH.
//  - Y = cdsel ? cdin : (fdbksel ? P_reg : 0); when shftsel=1, Y = Y >>> 17
//    (sign-filling shift).
//  - S = Y + c + carryin + (sub ? -M : M), wraps modulo 2^P_WIDTH.
//  - ovfl = 1 when the infinite-precision result is outside the signed P_WIDTH range.
//  - P register loads S and ovfl when en_p=1; bypassed -> p = S combinationally.
//  - Latency a/b -> p: 2 cycles with all registers on; each bypass removes one.
//    Latency c/cdin -> p: 1 cycle (0 if P bypassed).
//  - Control inputs (cdsel, fdbksel, shftsel, sub, carryin) are unregistered and
//    take effect in the same cycle.
// CONFIGURATION
//  - Macro MACC_FDBK_EN defined: fdbksel=1 with cdsel=0 feeds P_reg back, giving
//    accumulation.
//  - Macro undefined: fdbksel ignored and Y=0 whenever cdsel=0.
//  - Feedback with BYPASS_REG_P=1 is illegal; flag with a $display error at elaboration.
// STRUCTURE
//  - Package macc_pkg: P_WIDTH defaults per family, and the product width constant (36).
//  - Sub-module macc_pipe_reg (WIDTH, BYPASS): enable, srst_n, grst, bypass mux.
//    Instantiated for A, B and {ovfl,P}.
// TESTING
//  1. Default params: a=3, b=-5, c=0, cdsel=0, sub=0, one pulse of all enables
//     -> p=-15 two cycles later, ovfl=0.
//  2. cdsel=1, cdin=100, sub=1, a=4, b=5 -> p=80, and cdout equals p.
//  3. shftsel=1, cdsel=1, cdin=7<<17, a=b=0, c=1, carryin=1 -> p=9.
//  4. cdin=2^43-1, cdsel=1, a=b=1 -> p=-2^43 (wraps), ovfl=1.
//  5. grst pulse mid-stream with p nonzero -> p=0 asynchronously, before next clk edge.
//  6. MACC_FDBK_EN defined, a=2, b=3, cdsel=0, fdbksel=1, enables held 4 cycles from
//     reset -> p=6, 12, 18, 24. Without the macro -> p stays 6.

Source files
------------

// File: rtl/macc_pkg.sv
// Shared constants for the 18x18 MAC slice: product width and per-family adder widths.
package macc_pkg;
  localparam int AB_W   = 18;
  localparam int PROD_W = 36;

  typedef enum logic [1:0] {
    FAM_LEGACY  = 2'd0,
    FAM_DEFAULT = 2'd1,
    FAM_NEWEST  = 2'd2
  } macc_family_e;

  localparam int P_WIDTH_LEGACY  = 41;
  localparam int P_WIDTH_DEFAULT = 44;
  localparam int P_WIDTH_NEWEST  = 48;

  function automatic int p_width_of(macc_family_e fam);
    case (fam)
      FAM_LEGACY: return P_WIDTH_LEGACY;
      FAM_NEWEST: return P_WIDTH_NEWEST;
      default:    return P_WIDTH_DEFAULT;
    endcase
  endfunction
endpackage

// File: rtl/macc_18x18_if.sv
// Operand, control and result bundle of one MAC slice; P_WIDTH must match the slice.
interface macc_18x18_if
  import macc_pkg::*;
#(
  parameter int P_WIDTH = P_WIDTH_DEFAULT
);
  logic                      srst_n;
  logic                      en_a;
  logic                      en_b;
  logic                      en_p;
  logic signed [AB_W-1:0]    a;
  logic signed [AB_W-1:0]    b;
  logic signed [P_WIDTH-1:0] c;
  logic                      carryin;
  logic signed [P_WIDTH-1:0] cdin;
  logic                      cdsel;
  logic                      fdbksel;
  logic                      shftsel;
  logic                      sub;
  logic signed [P_WIDTH-1:0] p;
  logic signed [P_WIDTH-1:0] cdout;
  logic                      ovfl;

  modport master (
    output srst_n, en_a, en_b, en_p, a, b, c, carryin, cdin,
           cdsel, fdbksel, shftsel, sub,
    input  p, cdout, ovfl
  );

  modport slave (
    input  srst_n, en_a, en_b, en_p, a, b, c, carryin, cdin,
           cdsel, fdbksel, shftsel, sub,
    output p, cdout, ovfl
  );
endinterface

// File: rtl/macc_pipe_reg.sv
// Optional pipeline register: async clear, sync clear over enable, and a static bypass.
module macc_pipe_reg #(
  parameter int WIDTH  = 18,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             grst,
  input  logic             srst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_r;

  always_ff @(posedge clk or posedge grst) begin
    if (grst)         q_r <= '0;
    else if (!srst_n) q_r <= '0;
    else if (en)      q_r <= d;
  end

  // A bypassed stage leaves the flop dangling so synthesis trims it.
  assign q = BYPASS ? d : q_r;
endmodule

// File: rtl/macc_18x18.sv
// Signed 18x18 MAC slice: optional A/B/P registers, cascade and shift addend path.
// Define MACC_FDBK_EN to allow P feedback into the adder (accumulate mode).
module macc_18x18
  import macc_pkg::*;
#(
  parameter bit BYPASS_REG_A = 1'b0,
  parameter bit BYPASS_REG_B = 1'b0,
  parameter bit BYPASS_REG_P = 1'b0,
  parameter int P_WIDTH      = P_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         grst,
  macc_18x18_if.slave  bus
);
  // Three P_WIDTH-ish terms plus carry need two guard bits; one spare keeps it obvious.
  localparam int XW = P_WIDTH + 3;

  logic signed [AB_W-1:0]    ar, br;
  logic signed [PROD_W-1:0]  m;
  logic signed [P_WIDTH-1:0] p_reg;
  logic signed [P_WIDTH-1:0] y_sel, y;
  logic signed [XW-1:0]      y_x, c_x, cin_x, m_x, addend, s_wide;
  logic [P_WIDTH-1:0]        s;
  logic                      ovfl_c, ovfl_q;

  macc_pipe_reg #(.WIDTH(AB_W), .BYPASS(BYPASS_REG_A)) u_reg_a (
    .clk(clk), .grst(grst), .srst_n(bus.srst_n), .en(bus.en_a),
    .d(bus.a), .q(ar)
  );

  macc_pipe_reg #(.WIDTH(AB_W), .BYPASS(BYPASS_REG_B)) u_reg_b (
    .clk(clk), .grst(grst), .srst_n(bus.srst_n), .en(bus.en_b),
    .d(bus.b), .q(br)
  );

  assign m = ar * br;

`ifdef MACC_FDBK_EN
  generate
    if (BYPASS_REG_P) begin : g_fdbk_illegal
      $error("macc_18x18: MACC_FDBK_EN requires BYPASS_REG_P=0 (feedback would be a comb loop)");
    end
  endgenerate

  always_comb begin
    y_sel = '0;
    if (bus.cdsel)        y_sel = bus.cdin;
    else if (bus.fdbksel) y_sel = p_reg;
  end
`else
  logic unused_fdbksel;
  assign unused_fdbksel = bus.fdbksel;

  always_comb begin
    y_sel = '0;
    if (bus.cdsel) y_sel = bus.cdin;
  end
`endif

  assign y = bus.shftsel ? (y_sel >>> 17) : y_sel;

  assign y_x    = {{(XW-P_WIDTH){y[P_WIDTH-1]}}, y};
  assign c_x    = {{(XW-P_WIDTH){bus.c[P_WIDTH-1]}}, bus.c};
  assign cin_x  = {{(XW-1){1'b0}}, bus.carryin};
  assign m_x    = {{(XW-PROD_W){m[PROD_W-1]}}, m};
  assign addend = bus.sub ? -m_x : m_x;
  assign s_wide = y_x + c_x + cin_x + addend;
  assign s      = s_wide[P_WIDTH-1:0];

  // Exact sum fits the signed result only if every guard bit matches the result sign.
  assign ovfl_c = |s_wide[XW-1:P_WIDTH-1] & ~&s_wide[XW-1:P_WIDTH-1];

  macc_pipe_reg #(.WIDTH(P_WIDTH+1), .BYPASS(BYPASS_REG_P)) u_reg_p (
    .clk(clk), .grst(grst), .srst_n(bus.srst_n), .en(bus.en_p),
    .d({ovfl_c, s}), .q({ovfl_q, p_reg})
  );

  assign bus.p     = p_reg;
  assign bus.cdout = p_reg;
  assign bus.ovfl  = ovfl_q;
endmodule

// File: tb/tb_macc_18x18.sv
// Directed bench for macc_18x18 with a cycle-level arithmetic model and literal pins.
module tb_macc_18x18;
  localparam int PW = 44;
`ifdef MACC_FDBK_EN
  localparam bit FDBK = 1'b1;
`else
  localparam bit FDBK = 1'b0;
`endif
  localparam longint HALF = longint'(1) << (PW - 1);

  logic clk = 1'b0;
  logic grst;
  int   checks = 0;
  int   errors = 0;

  macc_18x18_if #(.P_WIDTH(PW)) bus ();

  macc_18x18 #(
    .BYPASS_REG_A(1'b0), .BYPASS_REG_B(1'b0), .BYPASS_REG_P(1'b0), .P_WIDTH(PW)
  ) dut (
    .clk(clk), .grst(grst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic longint sx(input logic [PW-1:0] v);
    longint r;
    r = longint'(v);
    if (v[PW-1]) r = r - (longint'(1) << PW);
    return r;
  endfunction

  function automatic longint wrap(input longint v);
    longint r;
    r = v & ((longint'(1) << PW) - 1);
    if (r >= HALF) r = r - 2 * HALF;
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: registered operands and result as plain integers.
  longint m_ar = 0, m_br = 0, m_p = 0;
  bit     m_ov = 1'b0;

  always @(posedge clk or posedge grst) begin : model
    longint y, prod, s;
    if (grst) begin
      m_ar <= 0; m_br <= 0; m_p <= 0; m_ov <= 1'b0;
    end else begin
      if (bus.cdsel)                y = sx(bus.cdin);
      else if (FDBK && bus.fdbksel) y = m_p;
      else                          y = 0;
      if (bus.shftsel) y = y >>> 17;
      prod = m_ar * m_br;
      s = y + sx(bus.c) + longint'(bus.carryin) + (bus.sub ? -prod : prod);
      if (!bus.srst_n) begin
        m_ar <= 0; m_br <= 0; m_p <= 0; m_ov <= 1'b0;
      end else begin
        if (bus.en_p) begin
          m_p  <= wrap(s);
          m_ov <= (s < -HALF) || (s >= HALF);
        end
        if (bus.en_a) m_ar <= longint'(bus.a);
        if (bus.en_b) m_br <= longint'(bus.b);
      end
    end
  end

  always @(negedge clk) begin : compare
    check("p_vs_model", sx(bus.p), m_p);
    check("cdout_vs_model", sx(bus.cdout), m_p);
    check("ovfl_vs_model", longint'(bus.ovfl), longint'(m_ov));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    grst = 1'b1;
    bus.srst_n = 1'b1; bus.en_a = 1'b0; bus.en_b = 1'b0; bus.en_p = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.carryin = 1'b0; bus.cdin = '0;
    bus.cdsel = 1'b0; bus.fdbksel = 1'b0; bus.shftsel = 1'b0; bus.sub = 1'b0;
    step(2);
    grst = 1'b0;
    check("reset_p", sx(bus.p), 0);
    check("reset_ovfl", longint'(bus.ovfl), 0);

    // 3 * -5 through both pipeline stages
    bus.a = 18'sd3; bus.b = -18'sd5; bus.en_a = 1'b1; bus.en_b = 1'b1; bus.en_p = 1'b1;
    step(1);
    bus.en_a = 1'b0; bus.en_b = 1'b0;
    step(1);
    check("mul_p", sx(bus.p), -15);
    check("mul_ovfl", longint'(bus.ovfl), 0);

    // cascade minus product: 100 - 4*5
    bus.cdsel = 1'b1; bus.cdin = 44'sd100; bus.sub = 1'b1;
    bus.a = 18'sd4; bus.b = 18'sd5; bus.en_a = 1'b1; bus.en_b = 1'b1;
    step(2);
    check("sub_p", sx(bus.p), 80);
    check("sub_cdout", sx(bus.cdout), 80);

    // (7<<17)>>>17 + 1 + carry
    bus.sub = 1'b0; bus.shftsel = 1'b1; bus.cdin = 44'sd7 << 17;
    bus.a = '0; bus.b = '0; bus.c = 44'sd1; bus.carryin = 1'b1;
    step(2);
    check("shift_p", sx(bus.p), 9);

    // positive wrap: (2^43-1) + 1
    bus.shftsel = 1'b0; bus.c = '0; bus.carryin = 1'b0;
    bus.cdin = 44'h7FF_FFFF_FFFF; bus.a = 18'sd1; bus.b = 18'sd1;
    step(2);
    check("wrap_pos_p", sx(bus.p), -HALF);
    check("wrap_pos_ovfl", longint'(bus.ovfl), 1);

    // negative wrap: -2^43 - 1
    bus.cdin = 44'h800_0000_0000; bus.sub = 1'b1;
    step(1);
    check("wrap_neg_p", sx(bus.p), HALF - 1);
    check("wrap_neg_ovfl", longint'(bus.ovfl), 1);

    // en_p low holds result and flag
    bus.en_p = 1'b0; bus.cdin = 44'sd5; bus.sub = 1'b0;
    step(2);
    check("hold_p", sx(bus.p), HALF - 1);
    check("hold_ovfl", longint'(bus.ovfl), 1);

    // most negative operands: (-2^17)^2 = 2^34
    bus.en_p = 1'b1; bus.cdsel = 1'b0; bus.a = 18'h20000; bus.b = 18'h20000;
    step(2);
    check("minmin_p", sx(bus.p), longint'(1) << 34);

    // sync clear beats enables and clears A/B too
    bus.srst_n = 1'b0;
    step(1);
    check("srst_p", sx(bus.p), 0);
    bus.srst_n = 1'b1; bus.en_a = 1'b0; bus.en_b = 1'b0;
    step(1);
    check("srst_ab_cleared", sx(bus.p), 0);

    // async reset mid-cycle
    bus.en_a = 1'b1; bus.en_b = 1'b1; bus.a = '0; bus.b = '0;
    bus.cdsel = 1'b1; bus.cdin = 44'sd1234;
    step(1);
    check("pre_grst_p", sx(bus.p), 1234);
    grst = 1'b1;
    #1;
    check("grst_async_p", sx(bus.p), 0);
    check("grst_async_cdout", sx(bus.cdout), 0);
    #1 grst = 1'b0;

    // feedback accumulation (holds at 6 when feedback is compiled out)
    bus.cdsel = 1'b0; bus.fdbksel = 1'b1; bus.cdin = '0;
    bus.a = 18'sd2; bus.b = 18'sd3;
    step(1);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check($sformatf("fdbk_p%0d", k), sx(bus.p), FDBK ? 6 * k : 6);
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
